// File: rtl/scan_arbiter_if.sv
// Requester/grant bundle shared between the scanners and the arbiter.
interface scan_arbiter_if;
    logic [1:0] req;
    logic [1:0] flushReq;
    logic [1:0] ack;
    logic [1:0] grant;
    logic [1:0] flushGo;

    // Scanner side: raises requests and acknowledges, observes grants.
    modport master (
        output req,
        output flushReq,
        output ack,
        input  grant,
        input  flushGo
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  flushReq,
        input  ack,
        output grant,
        output flushGo
    );
endinterface

// File: rtl/scan_arbiter.sv
// Two-scanner arbiter for a shared transfer channel with flush priority,
// round-robin tie-breaking and acknowledge timeout.
module scan_arbiter #(
    parameter int unsigned XFER_CYCLES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic                clk,
    input  logic                reset,
    scan_arbiter_if.slave       bus,
    output logic                busy,
    output logic                owner,
    output logic                timeoutErr,
    output logic [2:0]          state,
    output logic [3:0]          cycleCount
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b000,
        WAIT_ACK = 3'b001,
        XFER     = 3'b010,
        FLUSH    = 3'b011,
        RELEASE  = 3'b100
    } arb_state_e;

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             terr_q, terr_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       flush_go_q, flush_go_d;

    // Both requesting: favoured scanner wins; otherwise the lone requester.
    function automatic logic pick(input logic [1:0] bits, input logic rr);
        return (bits == 2'b11) ? rr : bits[1];
    endfunction

    // Next-state, owner/pointer update and registered-output preparation.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        terr_d     = 1'b0;
        cnt_d      = '0;
        grant_d    = 2'b00;
        flush_go_d = 2'b00;
        busy_d     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (|bus.flushReq) begin
                    state_d = FLUSH;
                    owner_d = pick(bus.flushReq, rr_ptr_q);
                end else if (|bus.req) begin
                    state_d = WAIT_ACK;
                    owner_d = pick(bus.req, rr_ptr_q);
                end
            end
            WAIT_ACK: begin
                if (bus.ack[owner_q]) begin
                    state_d = XFER;
                end else if (!bus.req[owner_q]) begin
                    state_d = RELEASE;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = RELEASE;
                    terr_d  = 1'b1;
                end
            end
            XFER: begin
                if (cnt_q == XFER_LAST) begin
                    state_d = RELEASE;
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d  = ARB_IDLE;
                rr_ptr_d = ~owner_q;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // In-state counter: restarts on every change, runs only in timed states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT_ACK || state_q == XFER || state_q == FLUSH) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d == WAIT_ACK || state_d == XFER) begin
            grant_d = owner_d ? 2'b10 : 2'b01;
        end
        if (state_d == FLUSH) begin
            flush_go_d = owner_d ? 2'b10 : 2'b01;
        end
        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            terr_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            flush_go_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            terr_q     <= terr_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            flush_go_q <= flush_go_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.flushGo = flush_go_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeoutErr  = terr_q;
    assign state       = state_q;
    assign cycleCount  = cnt_q;

endmodule

// File: tb/tb_scan_arbiter.sv
// Directed-vector bench for scan_arbiter with default parameters.
module tb_scan_arbiter;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       owner;
    logic       timeoutErr;
    logic [2:0] state;
    logic [3:0] cycleCount;

    int checks;
    int failures;

    logic [13:0] expv;
    wire  [13:0] obs;

    scan_arbiter_if bus ();

    scan_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .owner      (owner),
        .timeoutErr (timeoutErr),
        .state      (state),
        .cycleCount (cycleCount)
    );

    // Observed tuple: state, grant, flushGo, busy, owner, timeoutErr, cycleCount.
    assign obs = {state, bus.grant, bus.flushGo, busy, owner, timeoutErr, cycleCount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs hand-computed expected values in the same order as obs.
    function automatic logic [13:0] ev(input logic [2:0] s, input logic [1:0] g,
                                       input logic [1:0] f, input logic b,
                                       input logic o, input logic t, input logic [3:0] c);
        return {s, g, f, b, o, t, c};
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req = 2'b00; bus.flushReq = 2'b00; bus.ack = 2'b00;
        tick(); tick();
        expv = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL reset got=%h exp=%h", obs, expv); end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_single_transfer;
        logic [13:0] seq [0:4];
        seq[0] = ev(3'd1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        seq[1] = ev(3'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        seq[2] = ev(3'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        seq[3] = ev(3'd4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        seq[4] = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
        bus.req = 2'b01; bus.ack = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) begin bus.req = 2'b00; bus.ack = 2'b00; end
            checks++;
            if (obs !== seq[i]) begin failures++; $display("FAIL single[%0d] got=%h exp=%h", i, obs, seq[i]); end
        end
        // Pointer now favours scanner 1; then drop req in WAIT_ACK.
        bus.req = 2'b11;
        tick();
        expv = ev(3'd1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL rr_after_single got=%h exp=%h", obs, expv); end
        bus.req = 2'b00;
        tick();
        expv = ev(3'd4, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL req_drop_release got=%h exp=%h", obs, expv); end
        tick();
        expv = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL req_drop_idle got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_round_robin;
        logic       o;
        logic [1:0] g;
        pulse_reset();
        bus.req = 2'b11; bus.ack = 2'b11;
        for (int k = 0; k < 4; k++) begin
            o = (k % 2 == 1);
            g = o ? 2'b10 : 2'b01;
            for (int p = 0; p < 5; p++) begin
                tick();
                case (p)
                    0:       expv = ev(3'd1, g, 2'b00, 1'b1, o, 1'b0, 4'd0);
                    1:       expv = ev(3'd2, g, 2'b00, 1'b1, o, 1'b0, 4'd0);
                    2:       expv = ev(3'd2, g, 2'b00, 1'b1, o, 1'b0, 4'd1);
                    3:       expv = ev(3'd4, 2'b00, 2'b00, 1'b1, o, 1'b0, 4'd0);
                    default: expv = ev(3'd0, 2'b00, 2'b00, 1'b0, o, 1'b0, 4'd0);
                endcase
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL rr[%0d.%0d] got=%h exp=%h", k, p, obs, expv); end
            end
        end
        bus.req = 2'b00; bus.ack = 2'b00;
    endtask

    task automatic test_flush_priority;
        logic [13:0] seq [0:3];
        seq[0] = ev(3'd3, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 4'd0);
        seq[1] = ev(3'd3, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 4'd1);
        seq[2] = ev(3'd4, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0);
        seq[3] = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0);
        pulse_reset();
        bus.req = 2'b01; bus.flushReq = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin bus.req = 2'b00; bus.flushReq = 2'b00; end
            checks++;
            if (obs !== seq[i]) begin failures++; $display("FAIL flush[%0d] got=%h exp=%h", i, obs, seq[i]); end
        end
    endtask

    task automatic test_timeout;
        pulse_reset();
        // ack on the non-owner must not count.
        bus.req = 2'b10; bus.ack = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            expv = ev(3'd1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'(i));
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL timeout_wait[%0d] got=%h exp=%h", i, obs, expv); end
        end
        tick();
        expv = ev(3'd4, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL timeout_release got=%h exp=%h", obs, expv); end
        bus.req = 2'b00; bus.ack = 2'b00;
        tick();
        expv = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL timeout_idle got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_ack_at_timeout;
        // Pointer is back at 0 after the timeout on scanner 1.
        bus.req = 2'b11; bus.ack = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            expv = ev(3'd1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'(i));
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL ackto_wait[%0d] got=%h exp=%h", i, obs, expv); end
        end
        bus.ack = 2'b01;
        tick();
        expv = ev(3'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL ackto_xfer got=%h exp=%h", obs, expv); end
        bus.req = 2'b00; bus.ack = 2'b00;
        tick();
        expv = ev(3'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL ackto_xfer_hold got=%h exp=%h", obs, expv); end
        tick();
        expv = ev(3'd4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL ackto_release got=%h exp=%h", obs, expv); end
        tick();
    endtask

    task automatic test_reset_mid_xfer;
        // Pointer favours scanner 1 now.
        bus.req = 2'b10; bus.ack = 2'b10;
        tick(); tick(); tick();
        expv = ev(3'd2, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL midxfer_pre got=%h exp=%h", obs, expv); end
        reset = 1'b1;
        tick();
        expv = ev(3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL midxfer_reset got=%h exp=%h", obs, expv); end
        reset = 1'b0;
        bus.req = 2'b00; bus.ack = 2'b00;
        tick();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL midxfer_after got=%h exp=%h", obs, expv); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req = 2'b00; bus.flushReq = 2'b00; bus.ack = 2'b00;
        test_reset();
        test_single_transfer();
        test_round_robin();
        test_flush_priority();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
